// File: rtl/boot_sequencer_if.sv
// rtl/boot_sequencer_if.sv - ROM read / RAM write bus between boot_sequencer and memories
//
// Signals:
//   rom_en, rom_addr   ROM read strobe and address (sequencer drives)
//   rom_rdata          ROM read data, valid one cycle after rom_en (memory drives)
//   ram_we, ram_addr   RAM write strobe and address (sequencer drives)
//   ram_wdata          RAM write data (sequencer drives)
// Modports: master = sequencer side, slave = memory side.

interface boot_sequencer_if #(
    parameter int AW = 16,
    parameter int DW = 32
) ();
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;

    modport master (
        output rom_en,
        output rom_addr,
        input  rom_rdata,
        output ram_we,
        output ram_addr,
        output ram_wdata
    );

    modport slave (
        input  rom_en,
        input  rom_addr,
        output rom_rdata,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata
    );
endinterface

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - power-on sequencer: ROM-to-RAM boot copy, core reset hold, run budget
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-low reset
//   start       one-cycle (re)start request, honoured in IDLE and HALT only
//   mem         ROM read / RAM write bus (boot_sequencer_if.master)
//   core_rst    active-high reset to the core, low only in RUN
//   core_halt   high in HALT
//   busy        high in COPY, DRAIN and HOLD
//   tick_count  cycles spent in RUN since the last launch

module boot_sequencer #(
    parameter int          AW         = 16,
    parameter int          DW         = 32,
    parameter int unsigned BOOT_WORDS = 256,
    parameter int unsigned RST_HOLD   = 2,
    parameter int unsigned RUN_TICKS  = 40,
    parameter int unsigned AUTO_START = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    boot_sequencer_if.master       mem,
    output logic                   core_rst,
    output logic                   core_halt,
    output logic                   busy,
    output logic [31:0]            tick_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COPY  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    // Index is one bit wider than the address so a full 2^AW image
    // terminates on its last index instead of wrapping to zero.
    localparam logic [AW:0] LAST_IDX  = (AW+1)'((BOOT_WORDS == 0) ? 0 : BOOT_WORDS - 1);
    localparam logic [31:0] HOLD_LAST = 32'((RST_HOLD == 0) ? 0 : RST_HOLD - 1);
    localparam logic [31:0] RUN_LAST  = 32'((RUN_TICKS == 0) ? 0 : RUN_TICKS - 1);
    localparam bit          COPY_EN   = (BOOT_WORDS != 0);
    localparam bit          HALT_EN   = (RUN_TICKS != 0);
    localparam bit          AUTO_EN   = (AUTO_START != 0);

    logic [2:0]    state;
    logic [2:0]    state_n;
    logic          launch;
    logic [AW:0]   idx;
    logic [31:0]   hold_cnt;
    logic          auto_pend;
    logic          ram_we_q;
    logic [AW-1:0] ram_addr_q;

    always_comb begin
        state_n = state;
        launch  = 1'b0;
        case (state)
            S_IDLE:  if (start || auto_pend) launch = 1'b1;
            S_COPY:  if (idx == LAST_IDX) state_n = S_DRAIN;
            S_DRAIN: state_n = S_HOLD;
            S_HOLD:  if (hold_cnt == HOLD_LAST) state_n = S_RUN;
            S_RUN:   if (HALT_EN && (tick_count == RUN_LAST)) state_n = S_HALT;
            S_HALT:  if (start) launch = 1'b1;
            default: state_n = S_IDLE;
        endcase
        // An empty image skips straight to the reset hold.
        if (launch) state_n = COPY_EN ? S_COPY : S_HOLD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            hold_cnt   <= '0;
            tick_count <= '0;
            auto_pend  <= AUTO_EN;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
        end else begin
            state    <= state_n;
            // Write stage trails the read by one cycle, matching ROM latency.
            ram_we_q <= (state == S_COPY);
            if (state == S_COPY) ram_addr_q <= idx[AW-1:0];

            if (launch) begin
                idx        <= '0;
                hold_cnt   <= '0;
                tick_count <= '0;
                auto_pend  <= 1'b0;
            end
            if ((state == S_COPY) && (state_n == S_COPY)) idx <= idx + 1'b1;
            if (state == S_HOLD) hold_cnt <= hold_cnt + 32'd1;
            if (state == S_RUN) tick_count <= tick_count + 32'd1;
        end
    end

    assign mem.rom_en    = (state == S_COPY);
    assign mem.rom_addr  = idx[AW-1:0];
    assign mem.ram_we    = ram_we_q;
    assign mem.ram_addr  = ram_addr_q;
    // ROM data is only meaningful in the cycle after a read; gating keeps
    // idle ROM values off the write bus.
    assign mem.ram_wdata = ram_we_q ? mem.rom_rdata : '0;

    assign core_rst  = (state != S_RUN);
    assign core_halt = (state == S_HALT);
    assign busy      = (state == S_COPY) || (state == S_DRAIN) || (state == S_HOLD);

endmodule

// File: tb/tb_boot_sequencer.sv
// tb/tb_boot_sequencer.sv - self-checking bench for boot_sequencer

module tb_boot_sequencer;

    localparam int          AW     = 16;
    localparam int          DW     = 32;
    localparam logic [31:0] POISON = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    logic start = 1'b0;

    boot_sequencer_if #(.AW(AW), .DW(DW)) if_a ();
    boot_sequencer_if #(.AW(AW), .DW(DW)) if_b ();
    boot_sequencer_if #(.AW(AW), .DW(DW)) if_c ();

    logic        cr_a, ch_a, bz_a;
    logic        cr_b, ch_b, bz_b;
    logic        cr_c, ch_c, bz_c;
    logic [31:0] tk_a, tk_b, tk_c;

    boot_sequencer #(.AW(AW), .DW(DW), .BOOT_WORDS(256), .RST_HOLD(2), .RUN_TICKS(40), .AUTO_START(1))
        dut_a (.clk(clk), .rst(rst_a), .start(start), .mem(if_a),
               .core_rst(cr_a), .core_halt(ch_a), .busy(bz_a), .tick_count(tk_a));
    boot_sequencer #(.AW(AW), .DW(DW), .BOOT_WORDS(4), .RST_HOLD(2), .RUN_TICKS(0), .AUTO_START(0))
        dut_b (.clk(clk), .rst(rst_b), .start(start), .mem(if_b),
               .core_rst(cr_b), .core_halt(ch_b), .busy(bz_b), .tick_count(tk_b));
    boot_sequencer #(.AW(AW), .DW(DW), .BOOT_WORDS(0), .RST_HOLD(1), .RUN_TICKS(3), .AUTO_START(1))
        dut_c (.clk(clk), .rst(rst_c), .start(start), .mem(if_c),
               .core_rst(cr_c), .core_halt(ch_c), .busy(bz_c), .tick_count(tk_c));

    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        return 32'(a) ^ 32'hA5A5_0000;
    endfunction

    // ROM models: data valid exactly one cycle after a read, poison otherwise.
    always @(posedge clk) if_a.rom_rdata <= if_a.rom_en ? rom_word(if_a.rom_addr) : POISON;
    always @(posedge clk) if_b.rom_rdata <= if_b.rom_en ? rom_word(if_b.rom_addr) : POISON;
    always @(posedge clk) if_c.rom_rdata <= if_c.rom_en ? rom_word(if_c.rom_addr) : POISON;

    int sel = 0;
    logic          o_rom_en, o_ram_we, o_cr, o_ch, o_bz;
    logic [AW-1:0] o_rom_addr, o_ram_addr;
    logic [31:0]   o_wdata, o_tick;

    always_comb begin
        o_rom_en = if_a.rom_en;  o_rom_addr = if_a.rom_addr;
        o_ram_we = if_a.ram_we;  o_ram_addr = if_a.ram_addr; o_wdata = if_a.ram_wdata;
        o_cr = cr_a; o_ch = ch_a; o_bz = bz_a; o_tick = tk_a;
        if (sel == 1) begin
            o_rom_en = if_b.rom_en;  o_rom_addr = if_b.rom_addr;
            o_ram_we = if_b.ram_we;  o_ram_addr = if_b.ram_addr; o_wdata = if_b.ram_wdata;
            o_cr = cr_b; o_ch = ch_b; o_bz = bz_b; o_tick = tk_b;
        end else if (sel == 2) begin
            o_rom_en = if_c.rom_en;  o_rom_addr = if_c.rom_addr;
            o_ram_we = if_c.ram_we;  o_ram_addr = if_c.ram_addr; o_wdata = if_c.ram_wdata;
            o_cr = cr_c; o_ch = ch_c; o_bz = bz_c; o_tick = tk_c;
        end
    end

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int exp_rd      = 0;
    int nwr         = 0;
    int last_we_cyc = -1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    wr_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    task automatic sb_clear();
        sb.delete();
        exp_rd      = 0;
        nwr         = 0;
        last_we_cyc = -1;
    endtask

    // Writes are popped before this cycle's read is pushed, so a write that
    // coincides with its own read finds an empty queue.
    task automatic monitor();
        wr_t e;
        if (o_ram_we) begin
            nwr++;
            last_we_cyc = cyc;
            if (sb.size() == 0) begin
                chk1("unexpected_write", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("ram_addr", 32'(o_ram_addr), 32'(e.addr));
                chk("ram_wdata", o_wdata, e.data);
            end
        end
        if (o_rom_en) begin
            chk("rom_addr_seq", 32'(o_rom_addr), 32'(exp_rd));
            e.addr = AW'(exp_rd);
            e.data = rom_word(AW'(exp_rd));
            sb.push_back(e);
            exp_rd++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk1({tag, ".rom_en"}, o_rom_en, 1'b0);
        chk1({tag, ".ram_we"}, o_ram_we, 1'b0);
        chk1({tag, ".core_rst"}, o_cr, 1'b1);
        chk1({tag, ".core_halt"}, o_ch, 1'b0);
        chk1({tag, ".busy"}, o_bz, 1'b0);
        chk({tag, ".rom_addr"}, 32'(o_rom_addr), 32'd0);
        chk({tag, ".ram_addr"}, 32'(o_ram_addr), 32'd0);
        chk({tag, ".ram_wdata"}, o_wdata, 32'd0);
        chk({tag, ".tick"}, o_tick, 32'd0);
    endtask

    typedef struct {
        int            c;
        logic          st;
        logic          rom_en;
        logic [AW-1:0] rom_addr;
        logic          ram_we;
        logic [AW-1:0] ram_addr;
        logic          core_rst;
        logic          core_halt;
        logic          busy;
        logic [31:0]   tick;
    } vec_t;

    function automatic vec_t mk(input int c, input int st, input int re, input int ra,
                                input int we, input int wa, input int cr, input int ch,
                                input int bz, input int tk);
        vec_t v;
        v.c = c;           v.st = (st != 0);
        v.rom_en = (re != 0); v.rom_addr = AW'(ra);
        v.ram_we = (we != 0); v.ram_addr = AW'(wa);
        v.core_rst = (cr != 0); v.core_halt = (ch != 0);
        v.busy = (bz != 0);   v.tick = 32'(tk);
        return v;
    endfunction

    localparam int NV = 15;
    vec_t va[NV];

    initial begin
        //        cyc  st re  raddr we  waddr cr ch bz tick
        va[0]  = mk(  0, 0, 0,   0, 0,   0, 1, 0, 0,  0);
        va[1]  = mk(  1, 0, 1,   0, 0,   0, 1, 0, 1,  0);
        va[2]  = mk(  2, 0, 1,   1, 1,   0, 1, 0, 1,  0);
        va[3]  = mk(100, 1, 1,  99, 1,  98, 1, 0, 1,  0);
        va[4]  = mk(256, 0, 1, 255, 1, 254, 1, 0, 1,  0);
        va[5]  = mk(257, 0, 0,   0, 1, 255, 1, 0, 1,  0);
        va[6]  = mk(258, 0, 0,   0, 0,   0, 1, 0, 1,  0);
        va[7]  = mk(259, 0, 0,   0, 0,   0, 1, 0, 1,  0);
        va[8]  = mk(260, 0, 0,   0, 0,   0, 0, 0, 0,  0);
        va[9]  = mk(261, 0, 0,   0, 0,   0, 0, 0, 0,  1);
        va[10] = mk(270, 1, 0,   0, 0,   0, 0, 0, 0, 10);
        va[11] = mk(271, 0, 0,   0, 0,   0, 0, 0, 0, 11);
        va[12] = mk(299, 0, 0,   0, 0,   0, 0, 0, 0, 39);
        va[13] = mk(300, 0, 0,   0, 0,   0, 1, 1, 0, 40);
        va[14] = mk(305, 0, 0,   0, 0,   0, 1, 1, 0, 40);

        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("A.reset");

        // Default configuration, auto-start, table-driven timeline.
        rst_a = 1'b1;
        cyc = 0;
        sb_clear();
        for (int i = 0; i < NV; i++) begin
            run_to(va[i].c);
            chk1($sformatf("A.c%0d.rom_en", cyc), o_rom_en, va[i].rom_en);
            if (va[i].rom_en) chk($sformatf("A.c%0d.rom_addr", cyc), 32'(o_rom_addr), 32'(va[i].rom_addr));
            chk1($sformatf("A.c%0d.ram_we", cyc), o_ram_we, va[i].ram_we);
            if (va[i].ram_we) chk($sformatf("A.c%0d.ram_addr", cyc), 32'(o_ram_addr), 32'(va[i].ram_addr));
            chk1($sformatf("A.c%0d.core_rst", cyc), o_cr, va[i].core_rst);
            chk1($sformatf("A.c%0d.core_halt", cyc), o_ch, va[i].core_halt);
            chk1($sformatf("A.c%0d.busy", cyc), o_bz, va[i].busy);
            chk($sformatf("A.c%0d.tick", cyc), o_tick, va[i].tick);
            start = va[i].st;
            step();
            start = 1'b0;
        end
        chk("A.writes", 32'(nwr), 32'd256);
        chk("A.reads", 32'(exp_rd), 32'd256);
        chk("A.sb_empty", 32'(sb.size()), 32'd0);

        // Restart from HALT: full re-copy, tick cleared, second HALT.
        cyc = 0;
        sb_clear();
        pulse_start();
        chk1("A2.rom_en", o_rom_en, 1'b1);
        chk1("A2.core_halt", o_ch, 1'b0);
        chk1("A2.busy", o_bz, 1'b1);
        chk("A2.tick", o_tick, 32'd0);
        run_to(299);
        chk1("A2.c299.core_rst", o_cr, 1'b0);
        chk("A2.c299.tick", o_tick, 32'd39);
        step();
        chk1("A2.c300.core_halt", o_ch, 1'b1);
        chk1("A2.c300.core_rst", o_cr, 1'b1);
        chk("A2.c300.tick", o_tick, 32'd40);
        chk("A2.writes", 32'(nwr), 32'd256);

        // Reset at COPY word 100, released three cycles later.
        cyc = 0;
        sb_clear();
        pulse_start();
        run_to(101);
        chk("A3.rom_addr_at_abort", 32'(o_rom_addr), 32'd100);
        rst_a = 1'b0;
        #1;
        check_reset("A3.async");
        repeat (3) step();
        check_reset("A3.held");
        rst_a = 1'b1;
        cyc = 0;
        sb_clear();
        run_to(1);
        chk1("A3.c1.rom_en", o_rom_en, 1'b1);
        chk("A3.c1.rom_addr", 32'(o_rom_addr), 32'd0);
        run_to(259);
        chk1("A3.c259.core_rst", o_cr, 1'b1);
        step();
        chk1("A3.c260.core_rst", o_cr, 1'b0);
        chk("A3.writes", 32'(nwr), 32'd256);
        chk("A3.reads", 32'(exp_rd), 32'd256);
        rst_a = 1'b0;

        // N=4, no auto-start, run forever, start ignored in RUN.
        sel = 1;
        rst_b = 1'b1;
        cyc = 0;
        sb_clear();
        run_to(5);
        chk1("B.idle.busy", o_bz, 1'b0);
        chk1("B.idle.core_rst", o_cr, 1'b1);
        chk("B.idle.reads", 32'(exp_rd), 32'd0);
        cyc = 0;
        pulse_start();
        run_to(5);
        chk1("B.c5.rom_en", o_rom_en, 1'b0);
        chk1("B.c5.ram_we", o_ram_we, 1'b1);
        chk1("B.c5.busy", o_bz, 1'b1);
        run_to(8);
        chk1("B.c8.core_rst", o_cr, 1'b0);
        chk("B.c8.tick", o_tick, 32'd0);
        chk("B.writes", 32'(nwr), 32'd4);
        chk("B.last_write_cycle", 32'(last_we_cyc), 32'd5);
        run_to(20);
        pulse_start();
        run_to(30);
        chk("B.c30.tick", o_tick, 32'd22);
        chk1("B.c30.core_halt", o_ch, 1'b0);
        chk1("B.c30.core_rst", o_cr, 1'b0);
        chk1("B.c30.busy", o_bz, 1'b0);
        rst_b = 1'b0;

        // Empty image: straight to a one-cycle hold.
        sel = 2;
        rst_c = 1'b1;
        cyc = 0;
        sb_clear();
        run_to(1);
        chk1("C.c1.busy", o_bz, 1'b1);
        chk1("C.c1.core_rst", o_cr, 1'b1);
        chk1("C.c1.rom_en", o_rom_en, 1'b0);
        run_to(2);
        chk1("C.c2.core_rst", o_cr, 1'b0);
        chk1("C.c2.busy", o_bz, 1'b0);
        chk("C.c2.tick", o_tick, 32'd0);
        run_to(5);
        chk1("C.c5.core_halt", o_ch, 1'b1);
        chk("C.c5.tick", o_tick, 32'd3);
        run_to(8);
        chk("C.reads", 32'(exp_rd), 32'd0);
        chk("C.writes", 32'(nwr), 32'd0);
        rst_c = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
